// File: rtl/brick_collider.sv
`default_nettype none
// ============================================================================
// Module      : brick_collider
// Description : Per-frame ball/brick collision scanner. On each rising edge of
//               frame_clk the ball box is latched and the brick table is
//               walked one slot per clock, producing a hit mask and bounce
//               flags. Optional macro BRICK_COLLIDER_SINGLE_HIT_EN stops the
//               scan at the first hit.
// Revision    : 1.0 - initial release
// ============================================================================
module brick_collider #(
    parameter int NUM_BRICKS = 10,
    parameter int COORD_W    = 10
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          frame_clk,
    input  logic [COORD_W-1:0]            BallX,
    input  logic [COORD_W-1:0]            BallY,
    input  logic [COORD_W-1:0]            BallS,
    input  logic [NUM_BRICKS-1:0]         brick_exists,
    input  logic [NUM_BRICKS*COORD_W-1:0] brick_x_vals,
    input  logic [NUM_BRICKS*COORD_W-1:0] brick_y_vals,
    input  logic [COORD_W-1:0]            brick_width,
    input  logic [COORD_W-1:0]            brick_height,
    output logic [NUM_BRICKS-1:0]         hit_mask,
    output logic                          bounce_x,
    output logic                          bounce_y,
    output logic                          scan_done,
    output logic                          busy
);

    localparam int c_IDX_W = (NUM_BRICKS > 1) ? $clog2(NUM_BRICKS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_BRICKS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [COORD_W:0]   c_ONE      = (COORD_W + 1)'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SCAN = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic                  r_fc_q;
    logic                  w_start;
    logic [COORD_W-1:0]    r_bx;
    logic [COORD_W-1:0]    r_by;
    logic [COORD_W-1:0]    r_bs;
    logic [c_IDX_W-1:0]    r_idx;
    logic [NUM_BRICKS-1:0] r_work_mask;
    logic                  r_found;
    logic                  r_first_bx;
    logic                  r_first_by;
    logic [NUM_BRICKS-1:0] r_hit_mask;
    logic                  r_bounce_x;
    logic                  r_bounce_y;
    logic                  w_busy;
    logic                  w_scan_done;

    logic [COORD_W-1:0]    w_brk_x [NUM_BRICKS];
    logic [COORD_W-1:0]    w_brk_y [NUM_BRICKS];

    generate
        for (genvar gi = 0; gi < NUM_BRICKS; gi++) begin : g_unpack
            assign w_brk_x[gi] = brick_x_vals[gi*COORD_W +: COORD_W];
            assign w_brk_y[gi] = brick_y_vals[gi*COORD_W +: COORD_W];
        end
    endgenerate

    assign w_start = frame_clk & ~r_fc_q;

    // All box edges are carried one bit wider so bx+bs and x+w-1 never wrap.
    logic [COORD_W:0] w_ball_l;
    logic [COORD_W:0] w_ball_r;
    logic [COORD_W:0] w_ball_t;
    logic [COORD_W:0] w_ball_b;
    logic [COORD_W:0] w_ball_cx;
    logic [COORD_W:0] w_ball_cy;
    logic [COORD_W:0] w_brk_l;
    logic [COORD_W:0] w_brk_r;
    logic [COORD_W:0] w_brk_t;
    logic [COORD_W:0] w_brk_b;

    assign w_ball_l  = (r_bx >= r_bs) ? {1'b0, r_bx - r_bs} : '0;
    assign w_ball_t  = (r_by >= r_bs) ? {1'b0, r_by - r_bs} : '0;
    assign w_ball_r  = {1'b0, r_bx} + {1'b0, r_bs};
    assign w_ball_b  = {1'b0, r_by} + {1'b0, r_bs};
    assign w_ball_cx = {1'b0, r_bx};
    assign w_ball_cy = {1'b0, r_by};

    assign w_brk_l = {1'b0, w_brk_x[r_idx]};
    assign w_brk_t = {1'b0, w_brk_y[r_idx]};
    assign w_brk_r = w_brk_l + {1'b0, brick_width}  - c_ONE;
    assign w_brk_b = w_brk_t + {1'b0, brick_height} - c_ONE;

    logic w_ovl_x;
    logic w_ovl_y;
    logic w_hit;
    logic w_ctr_in_x;
    logic w_ctr_in_y;
    logic w_cur_bx;
    logic w_cur_by;

    assign w_ovl_x = (w_ball_l <= w_brk_r) && (w_ball_r >= w_brk_l);
    assign w_ovl_y = (w_ball_t <= w_brk_b) && (w_ball_b >= w_brk_t);
    assign w_hit   = (r_state == c_ST_SCAN) && brick_exists[r_idx] && w_ovl_x && w_ovl_y;

    assign w_ctr_in_x = (w_ball_cx >= w_brk_l) && (w_ball_cx <= w_brk_r);
    assign w_ctr_in_y = (w_ball_cy >= w_brk_t) && (w_ball_cy <= w_brk_b);

    // Centre above/below the brick reflects Y, beside it reflects X, corner both.
    assign w_cur_by = w_ctr_in_x | ~w_ctr_in_y;
    assign w_cur_bx = ~w_ctr_in_x;

    logic [NUM_BRICKS-1:0] w_hit_onehot;
    logic [NUM_BRICKS-1:0] w_mask_next;
    logic                  w_bnc_x_next;
    logic                  w_bnc_y_next;
    logic                  w_scan_last;

    assign w_hit_onehot = w_hit ? (NUM_BRICKS'(1) << r_idx) : '0;
    assign w_mask_next  = r_work_mask | w_hit_onehot;
    assign w_bnc_x_next = r_found ? r_first_bx : (w_hit & w_cur_bx);
    assign w_bnc_y_next = r_found ? r_first_by : (w_hit & w_cur_by);

`ifdef BRICK_COLLIDER_SINGLE_HIT_EN
    assign w_scan_last = (r_idx == c_LAST_IDX) || w_hit;
`else
    assign w_scan_last = (r_idx == c_LAST_IDX);
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_start)     w_state_next = c_ST_SCAN;
            c_ST_SCAN: if (w_scan_last) w_state_next = c_ST_DONE;
            c_ST_DONE:                  w_state_next = c_ST_IDLE;
            default:                    w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy      = 1'b0;
        w_scan_done = 1'b0;
        case (r_state)
            c_ST_SCAN: w_busy = 1'b1;
            c_ST_DONE: begin
                w_busy      = 1'b1;
                w_scan_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fc_q      <= 1'b0;
            r_bx        <= '0;
            r_by        <= '0;
            r_bs        <= '0;
            r_idx       <= '0;
            r_work_mask <= '0;
            r_found     <= 1'b0;
            r_first_bx  <= 1'b0;
            r_first_by  <= 1'b0;
            r_hit_mask  <= '0;
            r_bounce_x  <= 1'b0;
            r_bounce_y  <= 1'b0;
        end else begin
            r_fc_q <= frame_clk;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start) begin
                        r_bx        <= BallX;
                        r_by        <= BallY;
                        r_bs        <= BallS;
                        r_idx       <= '0;
                        r_work_mask <= '0;
                        r_found     <= 1'b0;
                        r_first_bx  <= 1'b0;
                        r_first_by  <= 1'b0;
                    end
                end
                c_ST_SCAN: begin
                    r_work_mask <= w_mask_next;
                    if (w_hit && !r_found) begin
                        r_found    <= 1'b1;
                        r_first_bx <= w_cur_bx;
                        r_first_by <= w_cur_by;
                    end
                    if (w_scan_last) begin
                        r_hit_mask <= w_mask_next;
                        r_bounce_x <= w_bnc_x_next;
                        r_bounce_y <= w_bnc_y_next;
                    end else begin
                        r_idx <= r_idx + c_IDX_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hit_mask  = r_hit_mask;
    assign bounce_x  = r_bounce_x;
    assign bounce_y  = r_bounce_y;
    assign scan_done = w_scan_done;
    assign busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_brick_collider.sv
`default_nettype none
// ============================================================================
// Module      : tb_brick_collider
// Description : Self-checking bench for brick_collider against a behavioural
//               box-overlap model; honours BRICK_COLLIDER_SINGLE_HIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_brick_collider;

    localparam int NB = 10;
    localparam int CW = 10;
`ifdef BRICK_COLLIDER_SINGLE_HIT_EN
    localparam bit c_SINGLE = 1'b1;
`else
    localparam bit c_SINGLE = 1'b0;
`endif

    logic            Clk = 1'b0;
    logic            Reset = 1'b1;
    logic            frame_clk = 1'b0;
    logic [CW-1:0]   BallX = '0, BallY = '0, BallS = '0;
    logic [NB-1:0]   brick_exists = '0;
    logic [NB*CW-1:0] brick_x_vals = '0, brick_y_vals = '0;
    logic [CW-1:0]   brick_width = '0, brick_height = '0;
    logic [NB-1:0]   hit_mask;
    logic            bounce_x, bounce_y, scan_done, busy;

    int errors = 0;
    int checks = 0;

    int tb_x [NB];
    int tb_y [NB];
    bit tb_live [NB];
    int tb_w, tb_h;

    brick_collider #(.NUM_BRICKS(NB), .COORD_W(CW)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .BallX(BallX), .BallY(BallY), .BallS(BallS),
        .brick_exists(brick_exists), .brick_x_vals(brick_x_vals),
        .brick_y_vals(brick_y_vals), .brick_width(brick_width),
        .brick_height(brick_height), .hit_mask(hit_mask),
        .bounce_x(bounce_x), .bounce_y(bounce_y),
        .scan_done(scan_done), .busy(busy)
    );

    always #5 Clk = ~Clk;

    task automatic clear_bricks();
        for (int i = 0; i < NB; i++) begin
            tb_x[i] = 900; tb_y[i] = 900; tb_live[i] = 1'b0;
        end
        tb_w = 40; tb_h = 10;
    endtask

    task automatic apply_bricks();
        for (int i = 0; i < NB; i++) begin
            brick_x_vals[i*CW +: CW] = CW'(tb_x[i]);
            brick_y_vals[i*CW +: CW] = CW'(tb_y[i]);
            brick_exists[i] = tb_live[i];
        end
        brick_width  = CW'(tb_w);
        brick_height = CW'(tb_h);
    endtask

    task automatic set_ball(input int x, input int y, input int s);
        BallX = CW'(x); BallY = CW'(y); BallS = CW'(s);
    endtask

    // Reference: inclusive box overlap, bounce from lowest-index hit.
    function automatic void model(input int bx, input int by, input int bs,
                                  output logic [NB-1:0] m, output logic ebx,
                                  output logic eby, output int lat);
        int l, r, t, b;
        bit found;
        m = '0; ebx = 1'b0; eby = 1'b0; lat = NB + 1; found = 1'b0;
        l = (bx - bs < 0) ? 0 : bx - bs;
        t = (by - bs < 0) ? 0 : by - bs;
        r = bx + bs;
        b = by + bs;
        for (int i = 0; i < NB; i++) begin
            if (!(c_SINGLE && found) && tb_live[i] &&
                l <= tb_x[i] + tb_w - 1 && r >= tb_x[i] &&
                t <= tb_y[i] + tb_h - 1 && b >= tb_y[i]) begin
                m[i] = 1'b1;
                if (!found) begin
                    found = 1'b1;
                    if (bx >= tb_x[i] && bx <= tb_x[i] + tb_w - 1) eby = 1'b1;
                    else if (by >= tb_y[i] && by <= tb_y[i] + tb_h - 1) ebx = 1'b1;
                    else begin ebx = 1'b1; eby = 1'b1; end
                    if (c_SINGLE) lat = i + 2;
                end
            end
        end
    endfunction

    // Starts a scan from a posedge+1 moment and observes 30 cycles.
    // k counts posedges after the start-sampling cycle; cycle N+k follows edge k.
    task automatic run_scan(input int ev2_k, input int rst_k,
                            output int lat, output int n_done, output int busy_cnt,
                            output logic [NB-1:0] m, output logic obx, output logic oby,
                            output logic [NB-1:0] final_m, output logic [3:0] rst_snap);
        lat = -1; n_done = 0; busy_cnt = 0; m = '0; obx = 1'b0; oby = 1'b0;
        rst_snap = 4'hF;
        frame_clk = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge Clk); #1;
            if (busy) busy_cnt++;
            if (scan_done) begin
                n_done++;
                if (lat < 0) begin
                    lat = k; m = hit_mask; obx = bounce_x; oby = bounce_y;
                end
            end
            if (k == rst_k + 1) rst_snap = {busy, bounce_x, bounce_y, |hit_mask};
            if (k == 2) frame_clk = 1'b0;
            if (k == ev2_k) frame_clk = 1'b1;
            if (k == ev2_k + 2) frame_clk = 1'b0;
            if (k == rst_k) Reset = 1'b1;
            if (k == rst_k + 1) Reset = 1'b0;
        end
        final_m = hit_mask;
    endtask

    task automatic test_reset();
        int lat, nd, bc, elat;
        logic [NB-1:0] m, fm, em;
        logic obx, oby, ebx, eby;
        logic [3:0] rs;
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (hit_mask !== '0 || bounce_x !== 1'b0 || bounce_y !== 1'b0 ||
            busy !== 1'b0 || scan_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got mask=%b bx=%b by=%b busy=%b done=%b, need all 0",
                     hit_mask, bounce_x, bounce_y, busy, scan_done);
        end
        Reset = 1'b0;
        @(posedge Clk); #1;
        clear_bricks(); apply_bricks(); set_ball(300, 300, 5);
        model(300, 300, 5, em, ebx, eby, elat);
        run_scan(0, 0, lat, nd, bc, m, obx, oby, fm, rs);
        checks++;
        if (lat !== NB + 1) begin
            errors++; $display("FAIL empty_latency: got %0d need %0d", lat, NB + 1);
        end
        checks++;
        if (m !== em || obx !== 1'b0 || oby !== 1'b0 || nd !== 1) begin
            errors++;
            $display("FAIL empty_scan: got mask=%b bx=%b by=%b dones=%0d need mask=%b 0 0 1",
                     m, obx, oby, nd, em);
        end
        checks++;
        if (bc !== NB + 1) begin
            errors++; $display("FAIL empty_busy: got %0d busy cycles need %0d", bc, NB + 1);
        end
    endtask

    task automatic test_vertical_horizontal();
        int lat, nd, bc, elat;
        logic [NB-1:0] m, fm, em;
        logic obx, oby, ebx, eby;
        logic [3:0] rs;
        clear_bricks();
        tb_x[3] = 100; tb_y[3] = 50; tb_live[3] = 1'b1;
        tb_x[6] = 400; tb_y[6] = 300; tb_live[6] = 1'b1;
        apply_bricks();
        set_ball(120, 62, 4);
        run_scan(0, 0, lat, nd, bc, m, obx, oby, fm, rs);
        checks++;
        if (m !== 10'b0000001000 || oby !== 1'b1 || obx !== 1'b0) begin
            errors++;
            $display("FAIL vertical_hit: got mask=%b bx=%b by=%b need 0000001000 0 1", m, obx, oby);
        end
        checks++;
        if (fm !== 10'b0000001000) begin
            errors++; $display("FAIL mask_hold: got %b need 0000001000", fm);
        end
        set_ball(96, 55, 4);
        run_scan(0, 0, lat, nd, bc, m, obx, oby, fm, rs);
        checks++;
        if (m !== 10'b0000001000 || obx !== 1'b1 || oby !== 1'b0) begin
            errors++;
            $display("FAIL horizontal_hit: got mask=%b bx=%b by=%b need 0000001000 1 0", m, obx, oby);
        end
        model(96, 55, 4, em, ebx, eby, elat);
        checks++;
        if (lat !== elat) begin
            errors++; $display("FAIL horizontal_latency: got %0d need %0d", lat, elat);
        end
        tb_live[3] = 1'b0; apply_bricks();
        run_scan(0, 0, lat, nd, bc, m, obx, oby, fm, rs);
        checks++;
        if (m !== '0 || obx !== 1'b0 || oby !== 1'b0) begin
            errors++;
            $display("FAIL dead_brick: got mask=%b bx=%b by=%b need 0 0 0", m, obx, oby);
        end
    endtask

    task automatic test_multi_hit();
        int lat, nd, bc, elat;
        logic [NB-1:0] m, fm, em;
        logic obx, oby, ebx, eby;
        logic [3:0] rs;
        clear_bricks();
        for (int i = 0; i < NB; i++) tb_live[i] = 1'b1;
        tb_x[2] = 100; tb_y[2] = 50;
        tb_x[5] = 118; tb_y[5] = 58;
        apply_bricks();
        set_ball(120, 62, 4);
        model(120, 62, 4, em, ebx, eby, elat);
        run_scan(0, 0, lat, nd, bc, m, obx, oby, fm, rs);
        checks++;
        if (m !== em) begin
            errors++; $display("FAIL multi_mask: got %b need %b", m, em);
        end
        checks++;
        if (lat !== elat || nd !== 1) begin
            errors++;
            $display("FAIL multi_latency: got lat=%0d dones=%0d need lat=%0d dones=1", lat, nd, elat);
        end
        checks++;
        if (obx !== ebx || oby !== eby) begin
            errors++;
            $display("FAIL multi_bounce: got bx=%b by=%b need bx=%b by=%b", obx, oby, ebx, eby);
        end
    endtask

    task automatic test_clamp_ignore();
        int lat, nd, bc, elat;
        logic [NB-1:0] m, fm, em;
        logic obx, oby, ebx, eby;
        logic [3:0] rs;
        clear_bricks();
        tb_x[0] = 0; tb_y[0] = 196; tb_live[0] = 1'b1; tb_w = 10; tb_h = 10;
        apply_bricks();
        set_ball(2, 200, 4);
        model(2, 200, 4, em, ebx, eby, elat);
        run_scan(5, 0, lat, nd, bc, m, obx, oby, fm, rs);
        checks++;
        if (m !== 10'b0000000001 || m !== em || oby !== eby || obx !== ebx) begin
            errors++;
            $display("FAIL left_clamp: got mask=%b bx=%b by=%b need mask=%b bx=%b by=%b",
                     m, obx, oby, em, ebx, eby);
        end
        checks++;
        if (nd !== 1 || lat !== elat) begin
            errors++;
            $display("FAIL busy_edge_ignored: got dones=%0d lat=%0d need 1 and %0d", nd, lat, elat);
        end
    endtask

    task automatic test_reset_mid_scan();
        int lat, nd, bc, elat;
        logic [NB-1:0] m, fm, em;
        logic obx, oby, ebx, eby;
        logic [3:0] rs;
        clear_bricks();
        for (int i = 0; i < NB; i++) begin
            tb_x[i] = 100; tb_y[i] = 50; tb_live[i] = 1'b1;
        end
        apply_bricks();
        set_ball(120, 62, 4);
        run_scan(0, 0, lat, nd, bc, m, obx, oby, fm, rs);
        run_scan(0, 6, lat, nd, bc, m, obx, oby, fm, rs);
        checks++;
        if (c_SINGLE ? (nd !== 1) : (nd !== 0)) begin
            errors++; $display("FAIL reset_mid_scan_done: got %0d scan_done pulses", nd);
        end
        if (!c_SINGLE) begin
            checks++;
            if (rs !== 4'b0000) begin
                errors++;
                $display("FAIL reset_mid_outputs: got busy,bx,by,|mask=%b need 0000", rs);
            end
        end
        model(120, 62, 4, em, ebx, eby, elat);
        run_scan(0, 0, lat, nd, bc, m, obx, oby, fm, rs);
        checks++;
        if (m !== em || lat !== elat || nd !== 1 || oby !== eby) begin
            errors++;
            $display("FAIL after_reset_scan: got mask=%b lat=%0d dones=%0d by=%b need %b %0d 1 %b",
                     m, lat, nd, oby, em, elat, eby);
        end
    endtask

    task automatic test_random();
        int lat, nd, bc, elat, bx, by, bs, ox, oy;
        logic [NB-1:0] m, fm, em;
        logic obx, oby, ebx, eby;
        logic [3:0] rs;
        for (int it = 0; it < 40; it++) begin
            bx = $urandom_range(0, 700);
            by = $urandom_range(0, 500);
            bs = $urandom_range(0, 12);
            tb_w = $urandom_range(5, 40);
            tb_h = $urandom_range(4, 16);
            for (int i = 0; i < NB; i++) begin
                ox = bx + $urandom_range(0, 70) - 55;
                oy = by + $urandom_range(0, 40) - 28;
                tb_x[i] = (ox < 0) ? 0 : ox;
                tb_y[i] = (oy < 0) ? 0 : oy;
                tb_live[i] = ($urandom_range(0, 3) != 0);
            end
            apply_bricks();
            set_ball(bx, by, bs);
            model(bx, by, bs, em, ebx, eby, elat);
            run_scan(0, 0, lat, nd, bc, m, obx, oby, fm, rs);
            checks++;
            if (m !== em || obx !== ebx || oby !== eby) begin
                errors++;
                $display("FAIL random_%0d: got mask=%b bx=%b by=%b need mask=%b bx=%b by=%b",
                         it, m, obx, oby, em, ebx, eby);
            end
            checks++;
            if (lat !== elat || nd !== 1 || bc !== elat || fm !== em) begin
                errors++;
                $display("FAIL random_timing_%0d: got lat=%0d dones=%0d busy=%0d hold=%b need %0d 1 %0d %b",
                         it, lat, nd, bc, fm, elat, elat, em);
            end
        end
    endtask

    initial begin
        clear_bricks();
        apply_bricks();
        test_reset();
        test_vertical_horizontal();
        test_multi_hit();
        test_clamp_ignore();
        test_reset_mid_scan();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/brick_collider.md
# brick_collider

Per-frame ball/brick collision engine between the ball motion stage and the brick list. On each rising edge of the frame strobe (VGA vsync), it latches the ball position and size. It then scans the brick table sequentially, one brick per clock. It reports which live bricks the ball overlaps and whether the ball must reflect in X and/or Y. BrickList consumes `hit_mask` to clear bricks; ball consumes `bounce_x`/`bounce_y` to invert velocity.

## Interface
- `NUM_BRICKS`, 10, number of brick slots scanned.
- `COORD_W`, 10, coordinate width in pixels.

- `Clk` input 1: system clock.
- `Reset` input 1: synchronous, active-high reset.
- `frame_clk` input 1: frame strobe (vsync), sampled in the `Clk` domain.
- `BallX`, `BallY` input COORD_W: ball centre.
- `BallS` input COORD_W: ball half-size (radius).
- `brick_exists` input NUM_BRICKS: bit i set means brick i is live.
- `brick_x_vals`, `brick_y_vals` input NUM_BRICKS*COORD_W: top-left corner of brick i at bits [i*COORD_W +: COORD_W].
- `brick_width`, `brick_height` input COORD_W: common brick size.
- `hit_mask` output NUM_BRICKS: bricks hit in the last completed scan.
- `bounce_x`, `bounce_y` output 1: reflect horizontal / vertical velocity.
- `scan_done` output 1: one-cycle pulse when the outputs update.
- `busy` output 1: high while scanning.

## Operation
- **Edge detect:** register `frame_clk` once, giving `fc_q`. A start condition is `frame_clk & ~fc_q`.
- **FSM states:**
  - IDLE → SCAN on start. Latch BallX/Y/S into `bx`/`by`/`bs`, clear the working mask, set index = 0.
  - SCAN: each cycle test brick[index].
    - If index == NUM_BRICKS-1, go to DONE.
    - Otherwise index++.
  - DONE: copy the working mask to `hit_mask`, drive the bounce flags, pulse `scan_done` → IDLE.
- **Brick inputs:** sampled live during SCAN; only the ball inputs are latched.
- **Overlap test (COORD_W+1 bit arithmetic, no wrap):**
  - Ball box: L = max(bx-bs, 0), R = bx+bs, T = max(by-bs, 0), B = by+bs.
  - Brick box: [x, x+w-1] × [y, y+h-1].
  - Hit when `brick_exists[i]` is set and the intervals overlap on both axes (inclusive).
- **Bounce decision, made from the first hit brick only (lowest index):**
  - If `bx` lies within [x, x+w-1]: set `bounce_y`.
  - Else if `by` lies within [y, y+h-1]: set `bounce_x`.
  - Otherwise (corner hit): set both.
  - No hit gives `bounce_x` = `bounce_y` = 0.
- **Dead bricks:** never hit, even if their coordinates overlap.
- **Reset values:** `hit_mask` = 0, `bounce_x` = `bounce_y` = 0, `scan_done` = 0, `busy` = 0, FSM in IDLE, `fc_q` = 0.

## Timing
- Start edge sampled at cycle N (`frame_clk` high, `fc_q` low). Then:
  - SCAN occupies cycles N+1 .. N+NUM_BRICKS.
  - DONE at N+NUM_BRICKS+1: `scan_done` = 1 and new outputs are visible that cycle.
- `busy` is high from N+1 through the DONE cycle inclusive.
- `hit_mask`/`bounce_*` hold their value until the next DONE. They do not pulse.
- A start edge while `busy` is ignored; it is not queued.
- `frame_clk` held high generates exactly one scan.
- `Reset` asserted mid-scan: next cycle IDLE, all outputs at reset values, no `scan_done`.
- Reset and a start edge in the same cycle: reset wins.

## Configuration
- `BRICK_COLLIDER_SINGLE_HIT_EN`
  - **Defined:** SCAN exits to DONE on the first hit. `hit_mask` is one-hot or zero, and latency becomes (index of first hit + 2) cycles after the start edge.
  - **Undefined:** all NUM_BRICKS are always scanned and every overlapping live brick is set in `hit_mask`. Fixed latency of NUM_BRICKS+1.

## Test plan
- **Reset** → `hit_mask` = 0, `bounce_x` = `bounce_y` = 0, `busy` = 0. Then pulse `frame_clk` with no live bricks → `scan_done` at start+11, mask 0, no bounce.
- **Vertical hit:** brick 3 live at (100,50), w = 40, h = 10; ball (120,62), S = 4 → `hit_mask` = 10'b0000001000, `bounce_y` = 1, `bounce_x` = 0.
- **Horizontal hit:** same brick, ball (96,55), S = 4 → `hit_mask` bit 3, `bounce_x` = 1, `bounce_y` = 0. With `brick_exists[3]` = 0 → mask 0.
- **Multi-hit:** bricks 2 and 5 both overlap the ball.
  - Macro undefined → mask 10'b0000100100, `scan_done` at start+11.
  - Macro defined → mask 10'b0000000100, `scan_done` at start+4.
- **Left-edge clamp:** ball (2,200), S = 4 against brick 0 at (0,196), w = 10, h = 10 → hit (no underflow). A second `frame_clk` edge at start+5 is ignored; exactly one `scan_done`.
- **Reset mid-scan:** `Reset` at start+6 → no `scan_done`, outputs 0. A fresh edge afterwards completes normally.
